// File: rtl/obstacle_spawner.sv
// Obstacle spawner: paces obstacle arrivals in video frames, picks car/truck and lane from a
// 16-bit Galois LFSR, drives the mux handshake and checks the mux's truck_out echo.
module obstacle_spawner #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          MIN_GAP       = 32,
    parameter int          GAP_BITS      = 5,
    parameter logic [8:0]  TRUCK_THRESH  = 9'd64,
    parameter int          MAX_TRUCK_RUN = 2,
    parameter int          LANE_LEFT     = 160,
    parameter int          LANE_WIDTH    = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        game_enable,
    input  logic        object_done,
    input  logic        truck_out,
    output logic        create_truck,
    output logic        object_ready,
    output logic [10:0] spawn_x,
    output logic [7:0]  spawn_count,
    output logic        type_error
);

    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS = 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        ISSUE,
        ACTIVE
    } state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [7:0]  gap_cnt_q;
    logic [7:0]  gap_reload_d;
    logic [7:0]  run_cnt_q;
    logic        truck_pick_d;
    logic [10:0] spawn_x_d;
    logic [1:0]  chk_q;
    logic        create_truck_q;
    logic        object_ready_q;
    logic [10:0] spawn_x_q;
    logic [7:0]  spawn_count_q;
    logic        type_error_q;

    assign lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    assign gap_reload_d = 8'(MIN_GAP) + 8'(lfsr_q[GAP_BITS-1:0]);
    assign truck_pick_d = ({1'b0, lfsr_q[15:8]} < TRUCK_THRESH)
                          && (run_cnt_q < 8'(MAX_TRUCK_RUN));
    assign spawn_x_d    = 11'(LANE_LEFT + int'(lfsr_q[5:4]) * LANE_WIDTH);

    // NOTE: every register here is assigned with <= so all branches see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            lfsr_q         <= SEED;
            gap_cnt_q      <= '0;
            run_cnt_q      <= '0;
            chk_q          <= '0;
            create_truck_q <= 1'b0;
            object_ready_q <= 1'b0;
            spawn_x_q      <= '0;
            spawn_count_q  <= '0;
            type_error_q   <= 1'b0;
        end else begin
            lfsr_q         <= lfsr_d;
            object_ready_q <= 1'b0;
            // chk_q[1] marks the cycle two after object_ready, when the mux echo is due.
            chk_q          <= {chk_q[0], object_ready_q};
            if (chk_q[1] && (truck_out != create_truck_q)) begin
                type_error_q <= 1'b1;
            end

            if (!game_enable) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        gap_cnt_q <= gap_reload_d;
                        state_q   <= GAP;
                    end
                    GAP: begin
                        if (startOfFrame) begin
                            if (gap_cnt_q == 8'd0) begin
                                create_truck_q <= truck_pick_d;
                                run_cnt_q      <= truck_pick_d ? run_cnt_q + 8'd1 : 8'd0;
                                spawn_x_q      <= spawn_x_d;
                                spawn_count_q  <= spawn_count_q + 8'd1;
                                object_ready_q <= 1'b1;
                                state_q        <= ISSUE;
                            end else begin
                                gap_cnt_q <= gap_cnt_q - 8'd1;
                            end
                        end
                    end
                    ISSUE: begin
                        state_q <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (object_done) begin
                            gap_cnt_q <= gap_reload_d;
                            state_q   <= GAP;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign create_truck = create_truck_q;
    assign object_ready = object_ready_q;
    assign spawn_x      = spawn_x_q;
    assign spawn_count  = spawn_count_q;
    assign type_error   = type_error_q;

endmodule
